// File: rtl/eth_vlg_pkg.sv
// Shared types and helpers for the eth_vlg frame buffer.
package eth_vlg_pkg;

    localparam int unsigned LEN_W = 16;

    // Descriptor pushed for every committed frame.
    typedef struct packed {
        logic [LEN_W-1:0] len;
    } frame_desc_t;

    // Read-side sequencing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } fbuf_state_t;

    // Byte counter add that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_add16(input logic [LEN_W-1:0] a,
                                                  input logic [LEN_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/eth_vlg_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module eth_vlg_dpram #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DEPTH_LOG-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_dat,
    input  logic [DEPTH_LOG-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_dat
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read data register; cleared so the buffer output is zero in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dat <= '0;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_vlg_frame_buf.sv
// Store-and-forward frame buffer: byte-stream in, request/ack frame delivery out.
// Only complete, error-free frames that fit are ever offered downstream.
module eth_vlg_frame_buf #(
    parameter int unsigned W          = 1,
    parameter int unsigned DEPTH_LOG  = 10,
    parameter int unsigned FRAMES_LOG = 3,
    parameter int unsigned DROP_ERR   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*W-1:0]         in_dat,
    input  logic                   in_val,
    input  logic                   in_err,
    input  logic [$clog2(W+1)-1:0] in_nb,
    output logic [8*W-1:0]         out_dat,
    output logic                   out_val,
    output logic [$clog2(W+1)-1:0] out_nb,
    output logic [15:0]            out_len,
    output logic                   out_rdy,
    input  logic                   out_req,
    output logic                   out_ack,
    output logic                   out_done,
    output logic                   err_drop,
    output logic                   ovf
);
    import eth_vlg_pkg::*;

    localparam int unsigned NBW       = $clog2(W+1);
    localparam int unsigned PW        = DEPTH_LOG + 1;
    localparam int unsigned FW        = FRAMES_LOG + 1;
    localparam int unsigned RAM_BEATS = 2**DEPTH_LOG;
    localparam int unsigned NFRAMES   = 2**FRAMES_LOG;

    // write side state
    logic [PW-1:0]    wr, wc;
    logic [15:0]      acc_len;
    logic             in_frame, over, bad;
    // descriptor fifo
    frame_desc_t      desc_mem   [NFRAMES];
    logic [PW-1:0]    desc_beats [NFRAMES];
    logic [FW-1:0]    wp, rp;
    // read side state
    fbuf_state_t      state, state_nx;
    logic [PW-1:0]    rd, rd_nx;
    logic [PW-1:0]    rem_beats, rem_beats_nx;
    logic [15:0]      rem_bytes, rem_bytes_nx;

    // combinational helpers
    logic             first_c, eof_c, space_c, desc_full_c, over_cur_c, wr_en_c;
    logic             over_nx_c, bad_nx_c, push_c, pop_c, drop_ovf_c, drop_err_c;
    logic [PW-1:0]    used_c;
    logic [FW-1:0]    desc_cnt_c, wp_nx_c, rp_nx_c, cnt_nx_c;
    logic [15:0]      len_nx_c;
    logic [FRAMES_LOG-1:0] head_c, head_nx_c;

    // registered-output next values
    logic             val_nx, ack_nx, done_nx, rdy_nx;
    logic [NBW-1:0]   nb_nx;
    logic [15:0]      len_out_nx;

    // Write-side framing, flag tracking and end-of-frame decision.
    always_comb begin
        first_c     = in_val && !in_frame;
        eof_c       = !in_val && in_frame;
        used_c      = wr - rd;
        space_c     = (used_c != PW'(RAM_BEATS));
        desc_cnt_c  = wp - rp;
        desc_full_c = (desc_cnt_c == FW'(NFRAMES));
        over_cur_c  = first_c ? desc_full_c : over;
        wr_en_c     = in_val && !over_cur_c && space_c;
        over_nx_c   = over;
        bad_nx_c    = bad;
        len_nx_c    = acc_len;
        if (in_val) begin
            over_nx_c = over_cur_c || !space_c;
            bad_nx_c  = (first_c ? 1'b0 : bad) || (in_err && (DROP_ERR != 0));
            len_nx_c  = first_c ? 16'(in_nb) : sat_add16(acc_len, 16'(in_nb));
        end
        push_c     = eof_c && !over && !bad;
        drop_ovf_c = eof_c && over;
        drop_err_c = eof_c && !over && bad;
        wp_nx_c    = wp + FW'(push_c);
    end

    // Write pointers and per-frame flags; a dropped frame rewinds to the commit point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr       <= '0;
            wc       <= '0;
            wp       <= '0;
            acc_len  <= '0;
            in_frame <= 1'b0;
            over     <= 1'b0;
            bad      <= 1'b0;
        end else begin
            in_frame <= in_val;
            over     <= over_nx_c;
            bad      <= bad_nx_c;
            acc_len  <= len_nx_c;
            wp       <= wp_nx_c;
            if (eof_c) begin
                if (push_c) begin
                    wc <= wr;
                end else begin
                    wr <= wc;
                end
            end else if (wr_en_c) begin
                wr <= wr + PW'(1);
            end
        end
    end

    // Descriptor storage; beat count kept alongside the length for the reader.
    always_ff @(posedge clk) begin
        if (push_c) begin
            desc_mem[wp[FRAMES_LOG-1:0]]   <= frame_desc_t'{len: acc_len};
            desc_beats[wp[FRAMES_LOG-1:0]] <= wr - wc;
        end
    end

    // Read FSM next state plus next values of the registered outputs.
    always_comb begin
        state_nx     = state;
        pop_c        = 1'b0;
        rd_nx        = rd;
        rem_beats_nx = rem_beats;
        rem_bytes_nx = rem_bytes;
        head_c       = rp[FRAMES_LOG-1:0];
        case (state)
            IDLE: begin
                if (out_req && (desc_cnt_c != '0)) begin
                    state_nx = ACK;
                end
            end
            ACK: begin
                rem_beats_nx = desc_beats[head_c];
                rem_bytes_nx = desc_mem[head_c].len;
                state_nx     = SEND;
            end
            SEND: begin
                rd_nx        = rd + PW'(1);
                rem_beats_nx = rem_beats - PW'(1);
                rem_bytes_nx = rem_bytes - 16'(W);
                if (rem_beats <= PW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                pop_c    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        rp_nx_c   = rp + FW'(pop_c);
        cnt_nx_c  = wp_nx_c - rp_nx_c;
        head_nx_c = rp_nx_c[FRAMES_LOG-1:0];

        val_nx  = (state_nx == SEND);
        ack_nx  = (state_nx == ACK);
        done_nx = (state_nx == DONE);
        rdy_nx  = (state_nx == IDLE) && (cnt_nx_c != '0);
        nb_nx   = '0;
        if (val_nx) begin
            nb_nx = (rem_beats_nx == PW'(1)) ? NBW'(rem_bytes_nx) : NBW'(W);
        end
        len_out_nx = '0;
        if (rdy_nx) begin
            // a frame committed into an empty fifo lands in the head slot this cycle
            len_out_nx = (push_c && (wp[FRAMES_LOG-1:0] == head_nx_c)) ? acc_len
                                                                        : desc_mem[head_nx_c].len;
        end
    end

    // Read FSM state register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd        <= '0;
            rp        <= '0;
            rem_beats <= '0;
            rem_bytes <= '0;
            out_val   <= 1'b0;
            out_nb    <= '0;
            out_len   <= '0;
            out_rdy   <= 1'b0;
            out_ack   <= 1'b0;
            out_done  <= 1'b0;
            err_drop  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nx;
            rd        <= rd_nx;
            rp        <= rp_nx_c;
            rem_beats <= rem_beats_nx;
            rem_bytes <= rem_bytes_nx;
            out_val   <= val_nx;
            out_nb    <= nb_nx;
            out_len   <= len_out_nx;
            out_rdy   <= rdy_nx;
            out_ack   <= ack_nx;
            out_done  <= done_nx;
            err_drop  <= drop_err_c;
            ovf       <= drop_ovf_c;
        end
    end

    // Read address runs one beat ahead during SEND to hide the RAM latency.
    eth_vlg_dpram #(
        .WIDTH     (8*W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (wr[DEPTH_LOG-1:0]),
        .wr_dat  (in_dat),
        .rd_addr (rd_nx[DEPTH_LOG-1:0]),
        .rd_dat  (out_dat)
    );

endmodule

// File: tb/tb_eth_vlg_frame_buf.sv
// Self-checking bench for eth_vlg_frame_buf (W=2, 16-beat RAM, 4 descriptors).
module tb_eth_vlg_frame_buf;

    localparam int unsigned W      = 2;
    localparam int unsigned DL     = 4;
    localparam int unsigned FL     = 2;
    localparam int          BEATS  = 16;
    localparam int          NDESC  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_dat = '0;
    logic        in_val = 1'b0;
    logic        in_err = 1'b0;
    logic [1:0]  in_nb = '0;
    logic [15:0] out_dat;
    logic        out_val;
    logic [1:0]  out_nb;
    logic [15:0] out_len;
    logic        out_rdy;
    logic        out_req = 1'b0;
    logic        out_ack;
    logic        out_done;
    logic        err_drop;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    // monitor counters (written only by the monitor)
    byte unsigned rx_bytes[$];
    int n_done = 0;
    int n_ovf  = 0;
    int n_err  = 0;

    // reference model: stored frames as a length list plus a flat byte stream
    int           m_lens[$];
    byte unsigned m_bytes[$];

    always #5 clk = ~clk;

    eth_vlg_frame_buf #(
        .W          (W),
        .DEPTH_LOG  (DL),
        .FRAMES_LOG (FL),
        .DROP_ERR   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_val   (in_val),
        .in_err   (in_err),
        .in_nb    (in_nb),
        .out_dat  (out_dat),
        .out_val  (out_val),
        .out_nb   (out_nb),
        .out_len  (out_len),
        .out_rdy  (out_rdy),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_done (out_done),
        .err_drop (err_drop),
        .ovf      (ovf)
    );

    // Collect delivered bytes and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_val) begin
                for (int i = 0; i < int'(out_nb); i++) rx_bytes.push_back(out_dat[8*i +: 8]);
            end
            if (out_done) n_done++;
            if (ovf)      n_ovf++;
            if (err_drop) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_frame(input int n, output byte unsigned d[$]);
        d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    endtask

    function automatic int model_free();
        int f;
        f = BEATS;
        foreach (m_lens[i]) f -= (m_lens[i] + 1) / 2;
        return f;
    endfunction

    // Frame acceptance from the buffer rules: descriptors, space, then error.
    task automatic model_add(input byte unsigned d[$], input int err_beat,
                             output bit e_ovf, output bit e_err);
        int beats;
        beats = (d.size() + 1) / 2;
        e_ovf = (m_lens.size() >= NDESC) || (beats > model_free());
        e_err = !e_ovf && (err_beat >= 0);
        if (!e_ovf && !e_err) begin
            m_lens.push_back(d.size());
            foreach (d[i]) m_bytes.push_back(d[i]);
        end
    endtask

    // Drive one frame; returns at the negedge of the end-of-frame cycle.
    task automatic drive_frame(input byte unsigned d[$], input int err_beat);
        int nbeats;
        nbeats = (d.size() + 1) / 2;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            in_val      = 1'b1;
            in_err      = (b == err_beat);
            in_dat[7:0] = d[2*b];
            if (2*b + 1 < d.size()) begin
                in_dat[15:8] = d[2*b+1];
                in_nb        = 2'd2;
            end else begin
                in_dat[15:8] = 8'($urandom);
                in_nb        = 2'd1;
            end
        end
        @(negedge clk);
        in_val = 1'b0;
        in_err = 1'b0;
        in_nb  = '0;
        in_dat = '0;
    endtask

    task automatic tx_frame(input byte unsigned d[$], input int err_beat, input string tag);
        bit e_ovf, e_err;
        int o0, e0;
        model_add(d, err_beat, e_ovf, e_err);
        o0 = n_ovf;
        e0 = n_err;
        drive_frame(d, err_beat);
        repeat (2) @(negedge clk);
        chk({tag, "_ovf"}, 32'(n_ovf - o0), 32'(e_ovf));
        chk({tag, "_errdrop"}, 32'(n_err - e0), 32'(e_err));
    endtask

    // Request the head frame and check ack, beats, bytes and done timing.
    task automatic rx_check(input string tag);
        int len, nbeats, to, enb;
        byte unsigned exp[$];
        len = m_lens.pop_front();
        exp = {};
        for (int i = 0; i < len; i++) exp.push_back(m_bytes.pop_front());
        to = 0;
        while (!out_rdy && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk({tag, "_rdy"}, 32'(out_rdy), 32'd1);
        chk({tag, "_len"}, 32'(out_len), 32'(len));
        out_req = 1'b1;
        @(negedge clk);
        out_req = 1'b0;
        chk({tag, "_ack"}, 32'(out_ack), 32'd1);
        chk({tag, "_val_at_ack"}, 32'(out_val), 32'd0);
        @(negedge clk);
        nbeats = (len + 1) / 2;
        for (int b = 0; b < nbeats; b++) begin
            enb = (b == nbeats - 1) ? len - 2*b : 2;
            chk({tag, "_val"}, 32'(out_val), 32'd1);
            chk({tag, "_nb"}, 32'(out_nb), 32'(enb));
            for (int j = 0; j < enb; j++)
                chk({tag, "_byte"}, 32'(out_dat[8*j +: 8]), 32'(exp[2*b + j]));
            @(negedge clk);
        end
        chk({tag, "_val_end"}, 32'(out_val), 32'd0);
        chk({tag, "_done"}, 32'(out_done), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(out_done), 32'd0);
    endtask

    initial begin
        byte unsigned d[$];
        byte unsigned exp5[$];
        int to, base_done, base_ovf, base_err, rx_base;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_val",  32'(out_val),  32'd0);
        chk("rst_rdy",  32'(out_rdy),  32'd0);
        chk("rst_ack",  32'(out_ack),  32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        chk("rst_dat",  32'(out_dat),  32'd0);
        chk("rst_len",  32'(out_len),  32'd0);
        chk("rst_nb",   32'(out_nb),   32'd0);
        chk("rst_ovf",  32'(ovf),      32'd0);
        chk("rst_errd", 32'(err_drop), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // request with nothing stored is ignored
        out_req = 1'b1;
        @(negedge clk);
        out_req = 1'b0;
        @(negedge clk);
        chk("idle_req_ack", 32'(out_ack), 32'd0);

        // test 1: 5-byte frame, exact commit and delivery timing
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        begin
            bit eo, ee;
            model_add(d, -1, eo, ee);
        end
        drive_frame(d, -1);
        chk("t1_rdy_at_eof", 32'(out_rdy), 32'd0);
        @(negedge clk);
        chk("t1_rdy_eof+1", 32'(out_rdy), 32'd1);
        chk("t1_len_eof+1", 32'(out_len), 32'd5);
        rx_check("t1");
        chk("t1_rdy_after", 32'(out_rdy), 32'd0);

        // test 2: errored frame dropped, good frame delivered
        rand_frame(6, d);
        tx_frame(d, 1, "t2_bad");
        chk("t2_rdy_bad", 32'(out_rdy), 32'd0);
        rand_frame(4, d);
        tx_frame(d, -1, "t2_good");
        rx_check("t2");
        chk("t2_rdy_after", 32'(out_rdy), 32'd0);

        // test 3: oversized frame overflows, next frame intact
        rand_frame(40, d);
        tx_frame(d, -1, "t3_big");
        chk("t3_rdy_big", 32'(out_rdy), 32'd0);
        rand_frame(8, d);
        tx_frame(d, -1, "t3_next");
        rx_check("t3");

        // test 4: descriptor exhaustion on the fifth frame
        for (int k = 0; k < 5; k++) begin
            rand_frame(2, d);
            tx_frame(d, -1, $sformatf("t4_f%0d", k));
        end
        for (int k = 0; k < 4; k++) rx_check($sformatf("t4_r%0d", k));
        chk("t4_rdy_after", 32'(out_rdy), 32'd0);

        // test 5: paced continuous traffic with req held high, pointers wrap
        base_done = n_done;
        base_ovf  = n_ovf;
        base_err  = n_err;
        rx_base   = rx_bytes.size();
        exp5      = {};
        out_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_frame(12, d);
            foreach (d[i]) exp5.push_back(d[i]);
            drive_frame(d, -1);
            repeat ($urandom_range(3, 5)) @(negedge clk);
        end
        to = 0;
        while ((n_done - base_done) < 10 && to < 500) begin
            @(negedge clk);
            to++;
        end
        out_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_frames", 32'(n_done - base_done), 32'd10);
        chk("t5_ovf", 32'(n_ovf - base_ovf), 32'd0);
        chk("t5_errdrop", 32'(n_err - base_err), 32'd0);
        chk("t5_bytes", 32'(rx_bytes.size() - rx_base), 32'd120);
        for (int i = 0; i < 120; i++) begin
            if (rx_base + i < rx_bytes.size())
                chk($sformatf("t5_byte%0d", i), 32'(rx_bytes[rx_base + i]), 32'(exp5[i]));
        end

        // test 6: reset during SEND
        rand_frame(10, d);
        tx_frame(d, -1, "t6_in");
        to = 0;
        while (!out_rdy && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("t6_rdy", 32'(out_rdy), 32'd1);
        out_req = 1'b1;
        @(negedge clk);
        out_req = 1'b0;
        chk("t6_ack", 32'(out_ack), 32'd1);
        @(negedge clk);
        chk("t6_beat1", 32'(out_val), 32'd1);
        @(negedge clk);
        chk("t6_beat2", 32'(out_val), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_val",  32'(out_val),  32'd0);
        chk("t6_rst_rdy",  32'(out_rdy),  32'd0);
        chk("t6_rst_ack",  32'(out_ack),  32'd0);
        chk("t6_rst_done", 32'(out_done), 32'd0);
        chk("t6_rst_dat",  32'(out_dat),  32'd0);
        m_lens.delete();
        m_bytes.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_rdy_post", 32'(out_rdy), 32'd0);
        end
        rand_frame(6, d);
        tx_frame(d, -1, "t6_new");
        rx_check("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_vlg_frame_buf.md
Name: eth_vlg_frame_buf

Overview:
Parametrised store-and-forward frame buffer between a phy-style byte stream (dat/val/err) and a flow-style consumer handshake (rdy/req/ack/done). It generalises the single-byte phy/flow pairing to W bytes per beat, multi-frame storage and error/overflow dropping. Sits between MAC RX and IPv4/TCP parsers, or between the TX header builder and the MAC. Only complete, error-free frames are ever presented downstream.

Parameters:
W, 1, bytes per beat; dat width is 8*W.
DEPTH_LOG, 10, log2 of data RAM depth in beats.
FRAMES_LOG, 3, log2 of frame descriptor FIFO depth.
DROP_ERR, 1, when 1 frames with in_err are discarded; when 0 err is ignored.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low.
in_dat  in  8*W  frame data; byte 0 in bits [7:0].
in_val  in  1  beat valid; a frame is one contiguous run of val=1.
in_err  in  1  error flag, sampled on any valid beat.
in_nb  in  $clog2(W+1)  valid bytes in beat; must be W except on the last beat.
out_dat  out  8*W  frame data out.
out_val  out  1  output beat valid.
out_nb  out  $clog2(W+1)  valid bytes in output beat.
out_len  out  16  byte length of the head frame; valid while out_rdy.
out_rdy  out  1  at least one complete frame stored and the reader is idle.
out_req  in  1  consumer request to send the head frame.
out_ack  out  1  one-cycle pulse: request accepted.
out_done  out  1  one-cycle pulse after the last beat of a frame.
err_drop  out  1  one-cycle pulse: frame discarded because of in_err.
ovf  out  1  one-cycle pulse: frame discarded because of space or descriptor shortage.

Behaviour:
- Reset (rst=0): all outputs 0; pointers, length counter and descriptor FIFO cleared; any stored or in-flight frames are lost.
- Pointers are DEPTH_LOG+1 bits: wr (write), wc (committed write), rd (read). Free space = 2^DEPTH_LOG - (wr - rd), modulo arithmetic.
- Write side:
  - Each valid beat is written at wr when space > 0; wr increments; byte count accumulates in_nb (16 bits, saturating).
  - An err beat with DROP_ERR=1 sets a bad flag. A beat arriving with no space sets an overflow flag, and writes stop.
  - If the descriptor FIFO is full on the first beat, the frame is flagged overflow.
  - End of frame is the first cycle with in_val=0 after val=1. That cycle:
    - overflow: wr<=wc, ovf pulse (overflow takes priority over bad).
    - else bad: wr<=wc, err_drop pulse.
    - else: push descriptor {len}, wc<=wr.
  - A new frame needs at least one idle cycle between frames.
- Read FSM:
  - IDLE: out_rdy = descriptor non-empty; out_len = head len. out_req=1 with out_rdy -> ACK. A request while not ready is ignored.
  - ACK: out_ack=1 for one cycle; issue the RAM read at rd. -> SEND.
  - SEND: out_val=1 for ceil(len/W) consecutive beats, no gaps; rd increments per beat. out_nb=W except the last beat, which carries len-(beats-1)*W. After the last beat -> DONE.
  - DONE: out_done=1; pop the descriptor. -> IDLE.
  - A req held high starts the next frame from IDLE.
- Latency:
  - Commit occurs at end-of-frame cycle e; out_rdy=1 at e+1.
  - req sampled at cycle n gives ack at n+1, first out_val at n+2, and done one cycle after the last beat.
- Simultaneous events: a commit and a pop in the same cycle both take effect. Reads free space only at beat consumption, so a concurrent write sees conservative space.
- Zero-length frames cannot occur (val=1 implies at least one beat). An in_nb=0 beat still consumes a beat.
- Frames longer than 2^DEPTH_LOG beats are always overflow-dropped.

Decomposition:
- eth_vlg_pkg: frame_desc_t struct {len[15:0]}; fbuf_state_t enum {IDLE, ACK, SEND, DONE}.
- Sub-module eth_vlg_dpram: simple dual-port RAM, parameters width/depth, registered read (1-cycle latency); one write port, one read port.
- The descriptor FIFO is inline registers.

Test Plan:
All tests use W=2, DEPTH_LOG=4 (32 bytes), FRAMES_LOG=2, DROP_ERR=1.
1. Write 5 bytes 01..05 (nb 2,2,1), then req -> ack at n+1; out_dat 0x0201, 0x0403, 0x??05 with nb 2,2,1 at n+2..n+4; done at n+5; out_rdy then 0.
2. A 6-byte frame with in_err on beat 2, then a good 4-byte frame -> err_drop pulse once; out_len=4 and only the good frame is read out.
3. A 40-byte frame -> ovf pulse at end-of-frame; out_rdy stays 0; a following 8-byte frame is accepted and read intact.
4. Five 2-byte frames with no reads -> 5th frame gives ovf; four reads return frames 1-4 in order; out_rdy=0 after.
5. Continuous traffic of 10 frames x 12 bytes with req held high -> pointers wrap; all 120 bytes match in order; no ovf/err_drop.
6. Assert rst=0 mid-SEND on beat 2 -> out_val, out_rdy, out_ack and out_done are all 0 immediately; after release, out_rdy=0 until a new frame is committed.
